control_pipe_unit: RTL
======================

Name: control_pipe_unit

Overview:
- Next-generation control unit for the RISC-V pipeline. It decodes Op/funct3/funct7 in the Decode stage and carries the control bundle through the E, M and W pipeline registers.
- Supports stall and flush, and extends the decode to RV32I ALU ops, JAL and LUI.
- Resolves the branch/jump decision (PCSrcE) in Execute.
- Sits between the instruction register (IF/ID) and the datapath stage registers.

Parameters:
- ALU_CTRL_W, 4: ALUControl width. Must be >= 4; codes are zero-extended.
- BRANCH_EXT, 0: 1 enables blt/bge/bltu/bgeu via LtE/LtuE. 0 treats those funct3 values as not-taken.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-low reset
- Op  in  7  instruction[6:0] (D stage)
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- StallE  in  1  hold the E-stage control register
- FlushE  in  1  insert a bubble into the E stage
- ZeroE  in  1  ALU zero flag (E stage)
- LtE  in  1  signed-less-than flag; used only when BRANCH_EXT=1
- LtuE  in  1  unsigned-less-than flag; used only when BRANCH_EXT=1
- ImmSrcD  out  3  immediate type, combinational (D stage)
- IllegalD  out  1  unsupported opcode, combinational
- RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  out  1 each  E-stage control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  ALU_CTRL_W  E-stage ALU operation
- PCSrcE  out  1  redirect PC, combinational from E regs and flags
- RegWriteM, MemWriteM  out  1 each  M-stage control
- ResultSrcM  out  2  M-stage result select
- RegWriteW  out  1  W-stage control
- ResultSrcW  out  2  W-stage result select

Behaviour:
- Opcode decode, fields are RegWrite / ALUSrc / MemWrite / ResultSrc / Branch / Jump / ImmSrc:
  - 0110011 R: 1/0/0/00/0/0/xxx
  - 0010011 I-ALU: 1/1/0/00/0/0/000
  - 0000011 load: 1/1/0/01/0/0/000
  - 0100011 store: 0/1/1/00/0/0/001
  - 1100011 branch: 0/0/0/00/1/0/010
  - 1101111 jal: 1/0/0/10/0/1/011
  - 0110111 lui: 1/1/0/00/0/0/100
  - Any other opcode: IllegalD=1, all enables 0, ImmSrcD=000 (bubble).
- ALUControl codes: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001, passB 1010.
- ALUControl by instruction class:
  - R-type, by funct3: 000 → sub if funct7[5] else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 → sra if funct7[5] else srl; 110 or; 111 and.
  - I-ALU: same table, except 000 is always add.
  - load, store, jal: add.
  - branch: sub.
  - lui: passB.
- D→E register also captures funct3 (funct3E, internal) for the branch decision.
- Register update priority on each clock edge: rst low > FlushE > StallE > normal advance.
- FlushE=1: E register loads zeros (bubble), M and W advance normally. FlushE together with StallE also gives a bubble in E.
- StallE=1 without FlushE: E register holds its value, M captures a bubble (zeros), W advances from M.
- Normal advance: E←decoded D, M←E (RegWrite, MemWrite, ResultSrc), W←M (RegWrite, ResultSrc).
- Each stage has a latency of 1 cycle. Decode-to-W takes 3 edges.
- PCSrcE = JumpE | (BranchE & take).
  - take: funct3E 000 → ZeroE; 001 → !ZeroE.
  - BRANCH_EXT=1: 100 → LtE; 101 → !LtE; 110 → LtuE; 111 → !LtuE.
  - Otherwise take=0.
- Reset (asynchronous, rst=0): every registered output and funct3E clear to 0, so PCSrcE=0. Combinational D outputs still follow Op.
- Release of rst is synchronous to clk. Reset mid-pipeline drops all in-flight control, and no write enable survives.

Test Plan:
- Reset: hold rst=0 with Op=0110011 → all E/M/W outputs 0, PCSrcE=0. Release rst, clock 3 edges → RegWriteW=1, ResultSrcW=00.
- R-type sub: Op=0110011, funct3=000, funct7=0100000 → after 1 edge ALUControlE=0001, RegWriteE=1, ALUSrcE=0. With funct7=0000000 → 0000. With funct3=101, funct7[5]=1 → 1000.
- Load/store through pipeline:
  - load (0000011): after 1 edge ResultSrcE=01; after 3 edges ResultSrcW=01, RegWriteW=1.
  - store (0100011): ImmSrcD=001 immediately, MemWriteM=1 after 2 edges, RegWriteW=0.
- Branch: beq with ZeroE=1 → PCSrcE=1. bne with ZeroE=1 → 0. BRANCH_EXT=0, funct3=100, LtE=1 → 0. BRANCH_EXT=1, same stimulus → 1. jal → PCSrcE=1, ResultSrcE=10.
- Stall/flush:
  - load in E, StallE=1 for 1 cycle → E unchanged (ResultSrcE=01), RegWriteM=0 next cycle.
  - FlushE=1 with StallE=1 → E all zero.
- Illegal opcode Op=1111111 → IllegalD=1, and 3 edges later RegWriteW=0, MemWriteM never 1.

Source files
------------

// File: rtl/control_pipe_unit_if.sv
// Control-unit signal bundle: D-stage instruction fields, hazard controls and E-stage flags in,
// per-stage control out.
interface control_pipe_unit_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [6:0]            Op;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  StallE;
  logic                  FlushE;
  logic                  ZeroE;
  logic                  LtE;
  logic                  LtuE;

  logic [2:0]            ImmSrcD;
  logic                  IllegalD;
  logic                  RegWriteE;
  logic                  MemWriteE;
  logic                  ALUSrcE;
  logic                  BranchE;
  logic                  JumpE;
  logic [1:0]            ResultSrcE;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic                  PCSrcE;
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic [1:0]            ResultSrcM;
  logic                  RegWriteW;
  logic [1:0]            ResultSrcW;

  // Datapath / pipeline side: supplies the instruction fields and flags, consumes the control.
  modport master (
    output Op, funct3, funct7, StallE, FlushE, ZeroE, LtE, LtuE,
    input  ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           ResultSrcE, ALUControlE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM,
           RegWriteW, ResultSrcW
  );

  // Control unit side.
  modport slave (
    input  Op, funct3, funct7, StallE, FlushE, ZeroE, LtE, LtuE,
    output ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           ResultSrcE, ALUControlE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM,
           RegWriteW, ResultSrcW
  );
endinterface

// File: rtl/control_pipe_unit.sv
// RISC-V pipelined control unit: decodes in D, carries the control bundle through E/M/W,
// and resolves the branch/jump redirect in E.
module control_pipe_unit #(
  parameter int ALU_CTRL_W = 4,
  parameter bit BRANCH_EXT = 1'b0
) (
  input logic                clk,
  input logic                rst,
  control_pipe_unit_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLL   = 4'b0110,
    ALU_SRL   = 4'b0111,
    ALU_SRA   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111
  } opcode_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    alu_op_t    alu_op;
    logic [2:0] funct3;
  } ctl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } ctl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctl_w_t;

  ctl_e_t     dec;
  logic [2:0] imm_src_d;
  logic       illegal_d;
  ctl_e_t     ctl_e;
  ctl_m_t     ctl_m;
  ctl_w_t     ctl_w;
  logic       take;

  // alt selects sub (funct3=000) or sra (funct3=101); other funct3 values ignore it.
  function automatic alu_op_t alu_arith(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.funct3 = bus.funct3;
    imm_src_d  = 3'b000;
    illegal_d  = 1'b0;
    case (bus.Op)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_arith(bus.funct3, bus.funct7[5]);
      end
      OP_I: begin
        // addi has no subtract form, so funct7[5] only matters for the shift-right pair
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = alu_arith(bus.funct3, bus.funct7[5] & (bus.funct3 != 3'b000));
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        imm_src_d     = 3'b001;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        imm_src_d  = 3'b010;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        imm_src_d      = 3'b011;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_PASSB;
        imm_src_d     = 3'b100;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Flush wins over stall in E; a stalled E must not also issue into M, so M takes a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_e <= '0;
      ctl_m <= '0;
      ctl_w <= '0;
    end else begin
      if (bus.FlushE)
        ctl_e <= '0;
      else if (!bus.StallE)
        ctl_e <= dec;

      if (bus.StallE && !bus.FlushE)
        ctl_m <= '0;
      else
        ctl_m <= '{reg_write: ctl_e.reg_write, mem_write: ctl_e.mem_write,
                   result_src: ctl_e.result_src};

      ctl_w <= '{reg_write: ctl_m.reg_write, result_src: ctl_m.result_src};
    end
  end

  always_comb begin
    take = 1'b0;
    case (ctl_e.funct3)
      3'b000:  take = bus.ZeroE;
      3'b001:  take = !bus.ZeroE;
      3'b100:  take = BRANCH_EXT & bus.LtE;
      3'b101:  take = BRANCH_EXT & !bus.LtE;
      3'b110:  take = BRANCH_EXT & bus.LtuE;
      3'b111:  take = BRANCH_EXT & !bus.LtuE;
      default: take = 1'b0;
    endcase
  end

  assign bus.ImmSrcD     = imm_src_d;
  assign bus.IllegalD    = illegal_d;
  assign bus.RegWriteE   = ctl_e.reg_write;
  assign bus.MemWriteE   = ctl_e.mem_write;
  assign bus.ALUSrcE     = ctl_e.alu_src;
  assign bus.BranchE     = ctl_e.branch;
  assign bus.JumpE       = ctl_e.jump;
  assign bus.ResultSrcE  = ctl_e.result_src;
  assign bus.ALUControlE = ALU_CTRL_W'(ctl_e.alu_op);
  assign bus.PCSrcE      = ctl_e.jump | (ctl_e.branch & take);
  assign bus.RegWriteM   = ctl_m.reg_write;
  assign bus.MemWriteM   = ctl_m.mem_write;
  assign bus.ResultSrcM  = ctl_m.result_src;
  assign bus.RegWriteW   = ctl_w.reg_write;
  assign bus.ResultSrcW  = ctl_w.result_src;

endmodule
